// File: rtl/mario_pkg.sv
// mario_pkg
//   Shared definitions for the sprite command dispatcher: command word field
//   positions, the swap marker value, default visible line count, dispatcher
//   state encoding, Avalon register addresses, and helpers for forming and
//   recognising buffer-swap words.
package mario_pkg;

    localparam int CMD_W = 32;

    // Command word field positions
    localparam int SUB_COMP_MSB   = 31;
    localparam int SUB_COMP_LSB   = 26;
    localparam int CHILD_COMP_MSB = 25;
    localparam int CHILD_COMP_LSB = 21;
    localparam int INFO_MSB       = 20;
    localparam int INFO_LSB       = 17;
    localparam int INPUT_TYPE_MSB = 16;
    localparam int INPUT_TYPE_LSB = 14;
    localparam int BUF_SEL_BIT    = 13;
    localparam int MSG_MSB        = 12;
    localparam int MSG_LSB        = 0;

    localparam logic [3:0] INFO_SWAP = 4'hF;

    localparam int V_ACTIVE_DEFAULT = 480;

    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_SWAP   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    typedef enum logic {
        DRAIN = 1'b0,
        HOLD  = 1'b1
    } disp_state_t;

    // Swap word: only the info marker and the new front-buffer bit are set.
    function automatic logic [CMD_W-1:0] make_swap_word(input logic front);
        logic [CMD_W-1:0] w;
        w = '0;
        w[INFO_MSB:INFO_LSB] = INFO_SWAP;
        w[BUF_SEL_BIT]       = front;
        return w;
    endfunction

    function automatic logic is_swap_word(input logic [CMD_W-1:0] w);
        return (w[INFO_MSB:INFO_LSB] == INFO_SWAP);
    endfunction

endpackage

// File: rtl/mario_cmd_fifo.sv
// mario_cmd_fifo
//   Synchronous single-clock FIFO holding pending command words.
//   Ports:
//     clk        in   system clock
//     reset      in   asynchronous active-low reset (pointers and count only)
//     push       in   write push_data at the tail (caller ensures space)
//     push_data  in   DATA_W word to enqueue
//     pop        in   discard the head (caller ensures not empty)
//     head       out  word at the head of the queue
//     full/empty out  occupancy flags
//     count      out  occupancy, log2(DEPTH)+1 bits
module mario_cmd_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mario_cmd_dispatcher.sv
// mario_cmd_dispatcher
//   Frame-synchronous replay of software-posted sprite commands onto the
//   shared display component command bus. Swap words wait for vertical
//   blanking and at most one swap is released per frame.
//   Ports:
//     clk, reset             clock; asynchronous active-low reset
//     chipselect/write/read  Avalon-MM slave strobes
//     address[1:0]           0 push command, 1 push swap, 2 status read
//     writedata[31:0]        Avalon write data
//     readdata[31:0]         registered status word (0 when status not built)
//     vcount[9:0]            current VGA line
//     cmd_out[31:0]          component command bus, 0 when idle
//   Build option: define MARIO_CMD_STATUS_EN to build the status register
//   and the saturating 8-bit overflow counter.
module mario_cmd_dispatcher
    import mario_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int V_ACTIVE = mario_pkg::V_ACTIVE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [9:0]  vcount,
    output logic [31:0] cmd_out
);

    localparam logic [9:0] VBLANK_LINE = 10'(V_ACTIVE);

    disp_state_t               state;
    disp_state_t               next_state;
    logic                      swapped;
    logic                      set_swapped;
    logic                      vblank_p0;
    logic                      vblank_p1;
    logic                      push_req;
    logic                      push_ok;
    logic                      pop;
    logic [CMD_W-1:0]          push_data;
    logic [CMD_W-1:0]          head;
    logic                      full;
    logic                      empty;
    logic [$clog2(DEPTH):0]    fifo_count;

    // Stage p0: decode Avalon writes into a FIFO push
    assign push_req  = chipselect & write & ((address == ADDR_CMD) | (address == ADDR_SWAP));
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push_ok   = push_req & (~full | pop);
    assign push_data = (address == ADDR_SWAP) ? make_swap_word(writedata[0]) : writedata;
    assign vblank_p0 = (vcount >= VBLANK_LINE);

    mario_cmd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_ok),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        set_swapped = 1'b0;
        case (state)
            DRAIN: begin
                if (!empty) begin
                    if (is_swap_word(head)) begin
                        next_state = HOLD;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (vblank_p0 && !swapped) begin
                    pop         = 1'b1;
                    set_swapped = 1'b1;
                    next_state  = DRAIN;
                end
            end
            default: next_state = DRAIN;
        endcase
    end

    // Stage p1: state, swap-per-frame flag and the registered command bus
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= DRAIN;
            swapped   <= 1'b0;
            vblank_p1 <= 1'b0;
            cmd_out   <= '0;
        end else begin
            state     <= next_state;
            vblank_p1 <= vblank_p0;
            cmd_out   <= pop ? head : '0;
            // Set and clear never coincide: a set needs vblank high now,
            // a clear needs it low now.
            if (set_swapped) begin
                swapped <= 1'b1;
            end else if (vblank_p1 && !vblank_p0) begin
                swapped <= 1'b0;
            end
        end
    end

`ifdef MARIO_CMD_STATUS_EN
    logic [7:0]  overflow_cnt;
    logic        overflow_p0;
    logic [7:0]  fill8;
    logic [31:0] status_word;

    assign overflow_p0 = push_req & ~push_ok;
    assign fill8       = 8'(fifo_count);
    assign status_word = {overflow_cnt, 7'd0, (state == HOLD), swapped, 7'd0, fill8};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_cnt <= '0;
            readdata     <= '0;
        end else begin
            if (overflow_p0 && (overflow_cnt != 8'hFF)) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end
            if (chipselect && read && (address == ADDR_STATUS)) begin
                readdata <= status_word;
            end
        end
    end
`else
    logic unused_status;
    assign unused_status = ^{read, fifo_count};
    assign readdata      = '0;
`endif

endmodule

// File: doc/mario_cmd_dispatcher.md
# mario_cmd_dispatcher

Frame-synchronous command dispatcher between the HPS Avalon-MM bridge and the sprite display components (`Mario_display` and its siblings). Software posts 32-bit sprite command words and buffer-swap requests into an internal FIFO. The block replays them in order onto the shared component command bus, one word per clock. Swap words are held until vertical blanking, so the ping/pong sprite state flips at most once per frame and never mid-scan.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 4..256.
- `V_ACTIVE`, 480: first non-visible line; `vblank` = `vcount >= V_ACTIVE`.

Ports:
- `clk` in 1: system clock (50 MHz).
- `reset` in 1: asynchronous, active-low reset.
- `chipselect` in 1: Avalon slave select.
- `write` in 1: Avalon write strobe.
- `read` in 1: Avalon read strobe.
- `address` in 2: 0 = push command, 1 = push swap request, 2 = status (read).
- `writedata` in 32: Avalon write data.
- `readdata` out 32: status word, registered.
- `vcount` in 10: current VGA line from the VGA counters.
- `cmd_out` out 32: command bus to all display components; 0 when idle, which is a no-op (info = 0).

## Operation
- Command word fields: [31:26] sub_comp, [25:21] child_comp, [20:17] info, [16:14] input_type, [13] buffer_select, [12:0] msg.
- Write to `address` 0: `writedata` is pushed unchanged.
- Write to `address` 1: the swap word `{6'd0, 5'd0, 4'hF, 3'd0, writedata[0], 13'd0}` is pushed. `writedata[0]` is the new front buffer.
- Write when the FIFO is full: the word is dropped and `overflow_cnt` increments (saturating).
- States:
  - DRAIN: head is a non-swap word → pop and drive it on `cmd_out` for exactly one cycle. Head is a swap word → HOLD. FIFO empty → `cmd_out` = 0.
  - HOLD: `cmd_out` = 0. When `vblank` is high and `swapped` = 0 → pop the swap word, drive it one cycle, set `swapped`, return to DRAIN. Commands behind the swap stay queued.
- `swapped` clears on the falling edge of `vblank` (registered `vcount` compare). This gives at most one swap per frame. A swap reaching the head mid-vblank after a swap already occurred waits for the next frame.
- Status read (`address` 2): {`overflow_cnt`[7:0], 7'd0, state==HOLD, `swapped`, 7'd0, fill[7:0]}.

## Timing
- Reset (asynchronous assert): `cmd_out` = 0, `readdata` = 0, FIFO empty, state DRAIN, `swapped` = 0, `overflow_cnt` = 0.
- Push latency: a word written at edge N is on `cmd_out` after edge N+1, held for one cycle, when the FIFO was empty and the state is DRAIN. There is no same-edge bypass.
- Throughput: one pop per clock.
- Simultaneous push and pop when full: the pop frees a slot and the push is accepted; no overflow count.
- Simultaneous push and pop when empty: the push is accepted and nothing pops.
- `readdata` is valid one cycle after `read`.
- Pointers wrap modulo `DEPTH`. `fill` uses a `log2(DEPTH)+1`-bit count.
- Reset mid-HOLD discards the pending swap and all queued words.

## Configuration
- `MARIO_CMD_STATUS_EN`:
  - Defined: status register and saturating 8-bit `overflow_cnt` are built.
  - Undefined: `readdata` is tied to 0, no counter is built, and overflow still drops silently.

## Structure
- `mario_pkg`: `INFO_SWAP` = 4'hF, command field bit positions, `V_ACTIVE` default, state enum `disp_state_t` {DRAIN, HOLD}, address constants.
- Sub-module `mario_cmd_fifo`: synchronous FIFO providing push, pop, head, full, empty and count.
- The FSM, swap-word formation and status logic live in the top module.

## Test plan
- Reset, then push 3 commands (`0x04220001`, `0x04240064`, `0x04260032`) on consecutive cycles → each appears on `cmd_out` for one cycle at edges 1, 2, 3 after its push; 0 afterwards.
- Push swap(1) while `vcount` = 100, then command `0x04220001` → `cmd_out` stays 0 until `vcount` = 480. Then `0x001E2000` for one cycle, then the command on the next cycle.
- Two swap requests in one frame, with `vcount` held at 490 → first emitted immediately, second held until `vcount` wraps below 480 and returns to 480.
- Push 17 words with `DEPTH` = 16 and `vcount` = 100, with a swap at the head → 16 queued, `overflow_cnt` = 1, status fill = 16.
- Assert `reset` low while in HOLD with 5 words queued → `cmd_out` = 0 immediately. After release, status reads 0 and no stale word is emitted at the next vblank.
